fifo_salida: RTL and testbench
==============================

// Module: fifo_salida
// PURPOSE
//  Output-side FIFO that terminates the arbiter's push/almost-full interface; one instance per destination (4 per switch).
//  Accepts push/data_in from the arbiter and exports empty/afull back to it.
//  Serves pop requests from the downstream consumer with registered read data.
//  Flags overflow and underflow.
// PARAMETERS
//  DATA_W    6  width of data word (payload + 2-bit dest)
//  DEPTH     8  number of entries; power of two, >= 4
//  AFULL_TH  6  afull asserts when count >= AFULL_TH; legal range 1..DEPTH-2
//  AEMPTY_TH 1  aempty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1
// PORTS
//  clk            in   1         rising-edge clock
//  reset          in   1         synchronous, active-high reset
//  push           in   1         write request from arbiter
//  data_in        in   DATA_W    write data, sampled with push
//  pop            in   1         read request from consumer
//  data_out       out  DATA_W    registered read data
//  valid_out      out  1         high one cycle after each accepted pop
//  empty          out  1         count == 0
//  full           out  1         count == DEPTH
//  afull          out  1         count >= afull threshold
//  aempty         out  1         count <= aempty threshold
//  count          out  CNT_W     occupancy 0..DEPTH; CNT_W = $clog2(DEPTH)+1
//  err_overflow   out  1         sticky: push rejected while full
//  err_underflow  out  1         sticky: pop rejected while empty
//  thr_load       in   1         (FIFO_THRESH_PROG_EN only) load thresholds
//  afull_th_in    in   CNT_W     (FIFO_THRESH_PROG_EN only) new afull threshold
//  aempty_th_in   in   CNT_W     (FIFO_THRESH_PROG_EN only) new aempty threshold
// BEHAVIOUR
//  - Reset (reset==1 at posedge) applies these values:
//      wr_ptr = rd_ptr = count = 0, data_out = 0, valid_out = 0.
//      empty = 1, aempty = 1, full = 0, afull = 0.
//      Both err flags = 0; thresholds = parameter values.
//  - Reset mid-operation discards all contents. Memory array is not cleared.
//  - Accept rules, evaluated per cycle:
//      push_ok = push & (!full | pop_ok)
//      pop_ok  = pop & !empty
//  - Push into an empty FIFO is never readable in the same cycle (no bypass).
//  - Write: on push_ok, mem[wr_ptr] <= data_in and wr_ptr increments, wrapping modulo DEPTH.
//  - Read latency is 1 cycle. On pop_ok, data_out <= mem[rd_ptr], rd_ptr wraps modulo DEPTH, and valid_out <= 1.
//    Otherwise data_out holds its value and valid_out <= 0.
//  - count <= count + push_ok - pop_ok.
//      Simultaneous push & pop when full: both are accepted and count stays at DEPTH.
//      Simultaneous push & pop when empty: push is accepted, pop is rejected and sets err_underflow, count becomes 1.
//  - Flags are decoded from the count register only, with no combinational path from push or pop.
//    The arbiter therefore sees afull one cycle after the push that crosses the threshold.
//    AFULL_TH <= DEPTH-2 guarantees absorption of in-flight pushes during the arbiter's 2-cycle stall window.
//  - err_overflow sets on push & full & !pop_ok; err_underflow sets on pop & empty. Both clear only on reset.
// CONFIGURATION
//  - FIFO_THRESH_PROG_EN defined:
//      thr_load, afull_th_in and aempty_th_in exist.
//      On thr_load, both threshold registers load from the ports, saturated to the legal ranges.
//      The new thresholds take effect in the cycle after loading, and reset restores the parameters.
//  - FIFO_THRESH_PROG_EN undefined:
//      These ports are absent and the thresholds are the constant parameters.
// STRUCTURE
//  - fifo_pkg: CNT_W/PTR_W derivation functions, threshold saturation function, reset-value localparams.
//  - Sub-module fifo_mem: DEPTH x DATA_W register array, 1 write port, registered read port with enable.
//  - Pointers, count, flags and errors stay in fifo_salida.
// TESTING
//  Defaults DEPTH=8, AFULL_TH=6.
//  1. Fill/drain: 8 pushes of 0x01..0x08, then 8 pops -> data_out = 0x01..0x08, each one cycle after its pop.
//     Then empty=1, count=0, no error flags.
//  2. Afull: push 6 words -> afull=1 in the cycle after the 6th push.
//     Pop 1 -> afull=0 in the cycle after the pop.
//  3. Boundaries:
//     Full, push+pop together -> count stays 8, err_overflow=0.
//     Empty, push+pop together -> count=1, err_underflow=1.
//  4. Wrap: 5 push, 5 pop, 7 push, 7 pop -> data in order across the pointer wrap, valid_out pulses exactly 12 times.
//  5. Reset: assert reset at count=4 -> next cycle count=0, empty=1, valid_out=0, error flags cleared.
//  6. FIFO_THRESH_PROG_EN: thr_load with afull_th_in=3 -> afull=1 once count reaches 3.
//     afull_th_in=9 saturates to 6.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers, threshold saturation and reset values for the output FIFO.
// Latency: none (compile-time constants and pure functions only).
// Backpressure: not applicable.
package fifo_pkg;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Pointer width: indexes 0..depth-1, so power-of-two depth wraps for free.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Clamp a requested threshold into [lo, hi].
    function automatic int sat(input int val, input int lo, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

    // Reset values of the registered state held in the FIFO.
    localparam logic RST_VALID = 1'b0;
    localparam logic RST_ERR   = 1'b0;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array, one write port, one registered read port with enable.
// Latency: read data appears one cycle after rd_en_i; write visible from the next cycle.
// Backpressure: none; caller guarantees legal addresses and enables.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [PTR_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic [PTR_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_dat_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_dat_q;

    // Storage array: deliberately not reset, contents are stale until rewritten.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    // Registered read port: holds its last value when no read is enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_dat_q <= '0;
        end else if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/fifo_salida.sv
// Output-side FIFO terminating the arbiter push/afull interface; optional FIFO_THRESH_PROG_EN adds loadable thresholds.
// Latency: 1 cycle pop-to-data (valid_out); flags decode the count register, so they lag the causing push/pop by 1 cycle.
// Backpressure: push while full is dropped unless a pop is accepted the same cycle (sticky err_overflow); pop while empty sets err_underflow.
module fifo_salida
    import fifo_pkg::*;
#(
    parameter  int DATA_W    = 6,
    parameter  int DEPTH     = 8,
    parameter  int AFULL_TH  = 6,
    parameter  int AEMPTY_TH = 1,
    localparam int CNT_W     = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              empty,
    output logic              full,
    output logic              afull,
    output logic              aempty,
    output logic [CNT_W-1:0]  count,
    output logic              err_overflow,
    output logic              err_underflow
`ifdef FIFO_THRESH_PROG_EN
    ,
    input  logic              thr_load,
    input  logic [CNT_W-1:0]  afull_th_in,
    input  logic [CNT_W-1:0]  aempty_th_in
`endif
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             valid_q,  valid_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic [CNT_W-1:0] afull_th_q;
    logic [CNT_W-1:0] aempty_th_q;
    logic             push_ok;
    logic             pop_ok;

`ifdef FIFO_THRESH_PROG_EN
    logic [CNT_W-1:0] afull_th_d;
    logic [CNT_W-1:0] aempty_th_d;

    // Next thresholds: clamp loaded values so afull can always absorb in-flight pushes.
    always_comb begin
        afull_th_d  = afull_th_q;
        aempty_th_d = aempty_th_q;
        if (thr_load) begin
            afull_th_d  = CNT_W'(sat(int'(afull_th_in),  1, DEPTH - 2));
            aempty_th_d = CNT_W'(sat(int'(aempty_th_in), 0, DEPTH - 1));
        end
    end

    // Threshold registers: reset restores the elaboration-time values.
    always_ff @(posedge clk) begin
        if (reset) begin
            afull_th_q  <= CNT_W'(AFULL_TH);
            aempty_th_q <= CNT_W'(AEMPTY_TH);
        end else begin
            afull_th_q  <= afull_th_d;
            aempty_th_q <= aempty_th_d;
        end
    end
`else
    assign afull_th_q  = CNT_W'(AFULL_TH);
    assign aempty_th_q = CNT_W'(AEMPTY_TH);
`endif

    // Status flags come only from registered count, never from push/pop directly.
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign afull  = (count_q >= afull_th_q);
    assign aempty = (count_q <= aempty_th_q);

    // Accept decisions and next-state for pointers, count, valid and error flags.
    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        valid_d  = pop_ok;
        ovf_d    = ovf_q | (push & full & ~pop_ok);
        unf_d    = unf_q | (pop & empty);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= RST_VALID;
            ovf_q    <= RST_ERR;
            unf_q    <= RST_ERR;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (push_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_dat_i  (data_in),
        .rd_en_i   (pop_ok),
        .rd_addr_i (rd_ptr_q),
        .rd_dat_o  (data_out)
    );

    assign valid_out     = valid_q;
    assign count         = count_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule

// File: tb/tb_fifo_salida.sv
// Directed bench for fifo_salida with a reference queue and an expected-output scoreboard.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: model applies the same accept rules on push/pop.
module tb_fifo_salida;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       afull;
    logic       aempty;
    logic [3:0] count;
    logic       err_overflow;
    logic       err_underflow;
`ifdef FIFO_THRESH_PROG_EN
    logic       thr_load;
    logic [3:0] afull_th_in;
    logic [3:0] aempty_th_in;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int vcnt   = 0;

    logic [5:0] mq[$];
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_salida dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .pop           (pop),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .empty         (empty),
        .full          (full),
        .afull         (afull),
        .aempty        (aempty),
        .count         (count),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
`ifdef FIFO_THRESH_PROG_EN
        ,
        .thr_load      (thr_load),
        .afull_th_in   (afull_th_in),
        .aempty_th_in  (aempty_th_in)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive push/pop, update the model, then check valid/data/count.
    task automatic step(input logic p, input logic q, input logic [5:0] d);
        bit pok;
        bit wok;
        pok = q && (mq.size() > 0);
        wok = p && ((mq.size() < 8) || pok);
        if (pok) exp_q.push_back(mq.pop_front());
        if (wok) mq.push_back(d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        if (valid_out === 1'b1) vcnt++;
        chk("valid_out", {31'd0, valid_out}, {31'd0, pok});
        if (valid_out === 1'b1 && exp_q.size() > 0) chk("data_out", {26'd0, data_out}, {26'd0, exp_q.pop_front()});
        chk("count", {28'd0, count}, mq.size());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        exp_q.delete();
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
`ifdef FIFO_THRESH_PROG_EN
        thr_load     = 1'b0;
        afull_th_in  = '0;
        aempty_th_in = '0;
`endif
        @(posedge clk);
        do_reset();
        chk("rst_count",  {28'd0, count}, 0);
        chk("rst_empty",  {31'd0, empty}, 1);
        chk("rst_aempty", {31'd0, aempty}, 1);
        chk("rst_full",   {31'd0, full}, 0);
        chk("rst_afull",  {31'd0, afull}, 0);
        chk("rst_valid",  {31'd0, valid_out}, 0);
        chk("rst_dout",   {26'd0, data_out}, 0);
        chk("rst_ovf",    {31'd0, err_overflow}, 0);
        chk("rst_unf",    {31'd0, err_underflow}, 0);

        // Fill and drain.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 6'(i));
        chk("fill_full",  {31'd0, full}, 1);
        chk("fill_aempty", {31'd0, aempty}, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'd0);
        chk("drain_empty", {31'd0, empty}, 1);
        chk("drain_ovf",   {31'd0, err_overflow}, 0);
        chk("drain_unf",   {31'd0, err_underflow}, 0);

        // Almost-full threshold crossing and release.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(8'h10 + i));
        chk("afull_at5", {31'd0, afull}, 0);
        step(1'b1, 1'b0, 6'h15);
        chk("afull_at6", {31'd0, afull}, 1);
        step(1'b0, 1'b1, 6'd0);
        chk("afull_after_pop", {31'd0, afull}, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 6'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'(8'h20 + i));
        step(1'b1, 1'b1, 6'h3F);
        chk("fullpp_full", {31'd0, full}, 1);
        chk("fullpp_ovf",  {31'd0, err_overflow}, 0);
        step(1'b1, 1'b0, 6'h2E);
        chk("ovf_set", {31'd0, err_overflow}, 1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'd0);

        // Empty with simultaneous push and pop.
        step(1'b1, 1'b1, 6'h2A);
        chk("emptypp_unf",   {31'd0, err_underflow}, 1);
        chk("emptypp_empty", {31'd0, empty}, 0);
        step(1'b0, 1'b1, 6'd0);

        // Reset mid-operation.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'(8'h30 + i));
        do_reset();
        chk("mrst_count", {28'd0, count}, 0);
        chk("mrst_empty", {31'd0, empty}, 1);
        chk("mrst_valid", {31'd0, valid_out}, 0);
        chk("mrst_ovf",   {31'd0, err_overflow}, 0);
        chk("mrst_unf",   {31'd0, err_underflow}, 0);

        // Pointer wrap.
        vcnt = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(i + 1));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 6'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 6'(8'h08 + i));
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 6'd0);
        step(1'b0, 1'b0, 6'd0);
        chk("wrap_pulses", vcnt, 12);
        chk("wrap_unf", {31'd0, err_underflow}, 0);

`ifdef FIFO_THRESH_PROG_EN
        // Programmable thresholds, including saturation of an out-of-range value.
        thr_load     = 1'b1;
        afull_th_in  = 4'd3;
        aempty_th_in = 4'd1;
        @(posedge clk);
        #1;
        thr_load = 1'b0;
        step(1'b1, 1'b0, 6'h01);
        step(1'b1, 1'b0, 6'h02);
        chk("prog_afull_2", {31'd0, afull}, 0);
        step(1'b1, 1'b0, 6'h03);
        chk("prog_afull_3", {31'd0, afull}, 1);
        thr_load    = 1'b1;
        afull_th_in = 4'd9;
        @(posedge clk);
        #1;
        thr_load = 1'b0;
        chk("sat_afull_3", {31'd0, afull}, 0);
        step(1'b1, 1'b0, 6'h04);
        step(1'b1, 1'b0, 6'h05);
        chk("sat_afull_5", {31'd0, afull}, 0);
        step(1'b1, 1'b0, 6'h06);
        chk("sat_afull_6", {31'd0, afull}, 1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 6'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
